// File: rtl/whack_pkg.sv
// whack_pkg: shared round states, BCD limits and the seconds-to-BCD helper.
package whack_pkg;
  typedef enum logic [1:0] {IDLE, PLAY, FINISH, OVER} state_e;
  localparam logic [3:0] BCD_MAX_TENS = 4'd9;
  localparam logic [3:0] BCD_MAX_ONES = 4'd9;
  function automatic logic [7:0] to_bcd2(input int v);
    logic [3:0] t, o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction
endpackage

// File: rtl/bcd2_counter.sv
// bcd2_counter: two-digit BCD counter with load, inc and dec, saturating at 00 and 99.
module bcd2_counter
  import whack_pkg::*;
#(
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       Clock,
  input  logic       reset,
  input  logic       load_i,
  input  logic       inc_i,
  input  logic       dec_i,
  input  logic [7:0] load_val_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o
);
  logic [3:0] tens_q, tens_d, ones_q, ones_d;
  logic       at_max, at_min, up, down;
  assign at_max = (tens_q == BCD_MAX_TENS) && (ones_q == BCD_MAX_ONES);
  assign at_min = (tens_q == 4'd0) && (ones_q == 4'd0);
  assign up     = inc_i && !dec_i && !at_max;
  assign down   = dec_i && !inc_i && !at_min;
  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (load_i) begin
      tens_d = load_val_i[7:4];
      ones_d = load_val_i[3:0];
    end else if (up) begin
      ones_d = (ones_q == BCD_MAX_ONES) ? 4'd0 : ones_q + 4'd1;
      tens_d = (ones_q == BCD_MAX_ONES) ? tens_q + 4'd1 : tens_q;
    end else if (down) begin
      ones_d = (ones_q == 4'd0) ? BCD_MAX_ONES : ones_q - 4'd1;
      tens_d = (ones_q == 4'd0) ? tens_q - 4'd1 : tens_q;
    end
  end
  always_ff @(posedge Clock) begin
    if (reset) begin
      tens_q <= RESET_VAL[7:4];
      ones_q <= RESET_VAL[3:0];
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end
  assign tens_o = tens_q;
  assign ones_o = ones_q;
endmodule

// File: rtl/score_game_ctrl.sv
// score_game_ctrl: Whack round FSM with BCD countdown, saturating score and high-score display.
module score_game_ctrl
  import whack_pkg::*;
#(
  parameter int GAME_SECONDS = 30,
  parameter int DISP_TICKS   = 2
) (
  input  logic       Clock,
  input  logic       reset,
  input  logic       start,
  input  logic       tick,
  input  logic       hit,
  input  logic       miss,
  output logic       game_active,
  output logic       round_done,
  output logic       show_high,
  output logic [3:0] score_tens,
  output logic [3:0] score_ones,
  output logic [3:0] time_tens,
  output logic [3:0] time_ones
);
  localparam logic [7:0] TIME_INIT = to_bcd2(GAME_SECONDS);
  localparam logic [3:0] DISP_LAST = 4'(DISP_TICKS - 1);
  state_e     state_q, state_d;
  logic [7:0] high_q, high_d, score, tmr;
  logic [3:0] disp_cnt_q, disp_cnt_d;
  logic       alt_q, alt_d, play, start_round, disp_wrap;
  assign play        = (state_q == PLAY);
  assign start_round = ((state_q == IDLE) || (state_q == OVER)) && start;
  assign disp_wrap   = (disp_cnt_q == DISP_LAST);
  bcd2_counter #(.RESET_VAL(8'h00)) u_score (
    .Clock      (Clock),
    .reset      (reset),
    .load_i     (start_round),
    .inc_i      (hit && play),
    .dec_i      (miss && play),
    .load_val_i (8'h00),
    .tens_o     (score[7:4]),
    .ones_o     (score[3:0])
  );
  bcd2_counter #(.RESET_VAL(TIME_INIT)) u_timer (
    .Clock      (Clock),
    .reset      (reset),
    .load_i     (start_round),
    .inc_i      (1'b0),
    .dec_i      (tick && play),
    .load_val_i (TIME_INIT),
    .tens_o     (tmr[7:4]),
    .ones_o     (tmr[3:0])
  );
  always_comb begin
    state_d    = state_q;
    high_d     = high_q;
    disp_cnt_d = disp_cnt_q;
    alt_d      = alt_q;
    case (state_q)
      IDLE:   state_d = start ? PLAY : IDLE;
      PLAY:   state_d = (tick && tmr == 8'h01) ? FINISH : PLAY;
      FINISH: begin
        state_d    = OVER;
        high_d     = (score > high_q) ? score : high_q;
        disp_cnt_d = 4'd0;
        alt_d      = 1'b0;
      end
      OVER: begin
        state_d    = start ? PLAY : OVER;
        disp_cnt_d = tick ? (disp_wrap ? 4'd0 : disp_cnt_q + 4'd1) : disp_cnt_q;
        alt_d      = (tick && disp_wrap) ? ~alt_q : alt_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clock) begin
    if (reset) begin
      state_q    <= IDLE;
      high_q     <= 8'h00;
      disp_cnt_q <= 4'd0;
      alt_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      high_q     <= high_d;
      disp_cnt_q <= disp_cnt_d;
      alt_q      <= alt_d;
    end
  end
  // BCD ordering matches binary ordering, so the 8-bit compare above is valid.
  assign game_active = play;
  assign round_done  = (state_q == FINISH);
  assign show_high   = (state_q == IDLE) || ((state_q == OVER) && alt_q);
  assign {score_tens, score_ones} = show_high ? high_q : score;
  assign {time_tens, time_ones}   = tmr;
endmodule

// File: tb/tb_score_game_ctrl.sv
// tb_score_game_ctrl: directed checks of rounds, saturation, high score and display alternation.
module tb_score_game_ctrl;
  logic       Clock, reset, start, tick, hit, miss;
  logic       game_active, round_done, show_high;
  logic [3:0] score_tens, score_ones, time_tens, time_ones;
  int         checks, errors;
  score_game_ctrl #(.GAME_SECONDS(30), .DISP_TICKS(2)) dut (
    .Clock       (Clock),
    .reset       (reset),
    .start       (start),
    .tick        (tick),
    .hit         (hit),
    .miss        (miss),
    .game_active (game_active),
    .round_done  (round_done),
    .show_high   (show_high),
    .score_tens  (score_tens),
    .score_ones  (score_ones),
    .time_tens   (time_tens),
    .time_ones   (time_ones)
  );
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input logic h, input logic m, input logic t);
    hit = h; miss = m; tick = t;
    @(posedge Clock);
    #1;
    hit = 1'b0; miss = 1'b0; tick = 1'b0;
  endtask
  task automatic do_start();
    start = 1'b1;
    step(0, 0, 0);
    start = 1'b0;
  endtask
  function automatic logic [7:0] sc();
    return {score_tens, score_ones};
  endfunction
  function automatic logic [7:0] tm();
    return {time_tens, time_ones};
  endfunction
  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; start = 1'b0; tick = 1'b0; hit = 1'b0; miss = 1'b0;
    step(0, 0, 0); step(0, 0, 0);
    chk("rst_active", 8'(game_active), 8'd0);
    chk("rst_done", 8'(round_done), 8'd0);
    chk("rst_show_high", 8'(show_high), 8'd1);
    chk("rst_score", sc(), 8'h00);
    chk("rst_time", tm(), 8'h30);
    reset = 1'b0;
    step(1, 0, 0);
    chk("idle_hit_ignored", sc(), 8'h00);
    do_start();
    chk("start_active", 8'(game_active), 8'd1);
    chk("start_show_high", 8'(show_high), 8'd0);
    chk("start_score", sc(), 8'h00);
    chk("start_time", tm(), 8'h30);
    repeat (12) step(1, 0, 0);
    chk("hits12", sc(), 8'h12);
    repeat (3) step(0, 1, 0);
    chk("miss_to_09", sc(), 8'h09);
    step(1, 1, 0);
    chk("hit_miss_both", sc(), 8'h09);
    step(1, 0, 0);
    chk("carry_09_10", sc(), 8'h10);
    step(0, 1, 0);
    chk("borrow_10_09", sc(), 8'h09);
    repeat (9) step(0, 1, 0);
    chk("down_to_00", sc(), 8'h00);
    repeat (3) step(0, 1, 0);
    chk("sat_00", sc(), 8'h00);
    repeat (98) step(1, 0, 0);
    chk("up_to_98", sc(), 8'h98);
    repeat (5) step(1, 0, 0);
    chk("sat_99", sc(), 8'h99);
    repeat (84) step(0, 1, 0);
    chk("back_to_15", sc(), 8'h15);
    step(1, 0, 1);
    chk("hit_tick_score", sc(), 8'h16);
    chk("hit_tick_time", tm(), 8'h29);
    step(0, 1, 0);
    repeat (28) step(0, 0, 1);
    chk("time_01", tm(), 8'h01);
    chk("still_play", 8'(game_active), 8'd1);
    step(0, 0, 1);
    chk("fin_done", 8'(round_done), 8'd1);
    chk("fin_active", 8'(game_active), 8'd0);
    chk("fin_show_high", 8'(show_high), 8'd0);
    chk("fin_score", sc(), 8'h15);
    chk("fin_time", tm(), 8'h00);
    step(0, 0, 0);
    chk("over_done_low", 8'(round_done), 8'd0);
    chk("over_show_score", 8'(show_high), 8'd0);
    step(1, 0, 0);
    chk("over_hit_ignored", sc(), 8'h15);
    step(0, 0, 1);
    chk("alt_tick1", 8'(show_high), 8'd0);
    step(0, 0, 1);
    chk("alt_tick2", 8'(show_high), 8'd1);
    chk("high_15", sc(), 8'h15);
    step(0, 1, 0);
    step(0, 0, 1);
    chk("alt_tick3", 8'(show_high), 8'd1);
    step(0, 0, 1);
    chk("alt_tick4", 8'(show_high), 8'd0);
    chk("over_miss_ignored", sc(), 8'h15);
    chk("over_time_00", tm(), 8'h00);
    do_start();
    chk("restart_active", 8'(game_active), 8'd1);
    chk("restart_score", sc(), 8'h00);
    chk("restart_time", tm(), 8'h30);
    repeat (7) step(1, 0, 0);
    repeat (30) step(0, 0, 1);
    chk("r2_done", 8'(round_done), 8'd1);
    chk("r2_score", sc(), 8'h07);
    step(0, 0, 0);
    step(0, 0, 1);
    step(0, 0, 1);
    chk("r2_show_high", 8'(show_high), 8'd1);
    chk("r2_high_kept", sc(), 8'h15);
    do_start();
    repeat (22) step(1, 0, 0);
    repeat (16) step(0, 0, 1);
    chk("mid_score", sc(), 8'h22);
    chk("mid_time", tm(), 8'h14);
    reset = 1'b1;
    step(0, 0, 0);
    reset = 1'b0;
    chk("mid_rst_active", 8'(game_active), 8'd0);
    chk("mid_rst_show_high", 8'(show_high), 8'd1);
    chk("mid_rst_high", sc(), 8'h00);
    chk("mid_rst_time", tm(), 8'h30);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
